hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central hazard/forwarding controller for the 5-stage MIPS pipeline.
- Tracks destination register and result-readiness of instructions in E, M and W in its own shadow pipeline.
- Drives decode-stage compare-operand forward selects (ForwardA_D/ForwardB_D), execute-stage ALU-operand selects, and stall/flush.
- Sits beside the datapath; owns the select inputs of the CMP and ALU operand muxes.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (MDU_STALL_EN only)
- DIV_CYC, 10, busy cycles for div/divu (MDU_STALL_EN only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rs_D  in  5  decode rs field
- rt_D  in  5  decode rt field
- tuse_rs_D  in  2  cycles until rs needed (0=branch compare, 1=ALU in E, 2=store data in M, 3=unused)
- tuse_rt_D  in  2  same for rt
- dst_D  in  5  decode write register (0 = no write)
- rtype_D  in  2  result source: 00 none, 01 ALU, 10 MEM, 11 PC8
- md_start_D  in  2  00 none, 01 mult, 10 div (MDU_STALL_EN)
- md_use_D  in  1  instruction reads or writes HI/LO (MDU_STALL_EN)
- ForwardA_D  out  2  CMP A select: 00 RD1, 01 ALU_O_M, 10 pc8 (M stage)
- ForwardB_D  out  2  CMP B select, same encoding
- ForwardA_E  out  2  ALU A select: 00 reg, 01 ALU_O_M, 10 pc8_M, 11 W result
- ForwardB_E  out  2  ALU B select, same encoding
- stall  out  1  freeze PC and F/D register
- flush_E  out  1  clear D/E register (bubble)

Behaviour:
- Shadow regs per stage (E, M, W): dst (5), rtype (2), tnew (2). Advance every clk.
- On stall, E receives a bubble (dst=0, rtype=00).
- tnew on entry to E:
  - ALU: 1
  - MEM: 2
  - PC8: 0
  - none: 0
- tnew decrements by 1 (saturating at 0) per stage advance.
- rs/rt E-stage shadow copies are also captured from rs_D/rt_D, or zeroed on stall.
- Hazard on operand X (rs or rt): X!=0, and some stage S in {E, M} has dst_S==X, with tnew_S > tuse_X_D.
- stall = OR of hazards over rs and rt. Purely combinational from current inputs and shadow state. flush_E = stall.
- Decode forward (ForwardA_D for rs, ForwardB_D for rt):
  - 01 if dst_M==X, X!=0, rtype_M==ALU.
  - 10 if dst_M==X, X!=0, rtype_M==PC8.
  - else 00.
  - W-stage values reach D through register-file write-first bypass; not forwarded here.
  - E-stage matches never forward to D; they stall, or are the PC8 case handled when the instruction reaches M.
- Execute forward (ForwardA_E/ForwardB_E from shadow rs_E/rt_E):
  - M match with rtype ALU → 01; with rtype PC8 → 10.
  - else W match with rtype!=none → 11.
  - else 00.
  - M has priority over W. Register 0 never forwards.
- Youngest producer wins: E match masks M, M match masks W.
- Reset: all shadow regs zero (bubbles). All outputs 00/0 in the cycle after reset asserts. Reset mid-stall clears the stall next cycle.

Optional Feature:
- Macro: MDU_STALL_EN.
- Enabled:
  - md_busy counter loads MULT_CYC or DIV_CYC when md_start_D enters E unstalled.
  - Counter decrements to 0 each cycle.
  - stall additionally asserts when md_use_D && (md_busy!=0 || md_start in E).
  - Reset clears the counter.
  - A new md_start while busy is itself stalled by the md_use rule (md_start implies md_use).
- Disabled: counter and md ports absent from logic; inputs ignored; stall is data-hazard-only.

Decomposition:
- Package hazard_pkg:
  - rtype encodings (RT_NONE, RT_ALU, RT_MEM, RT_PC8)
  - forward-select encodings (FWD_RF, FWD_ALU_M, FWD_PC8_M, FWD_W)
  - tnew table constants
- One natural sub-module: fwd_sel, a pure combinational priority comparator. Instantiated four times: D-A, D-B, E-A, E-B.

Test Plan:
- addu $1 → beq $1,$2 next cycle → stall=1 one cycle, then ForwardA_D=01 when addu in M, stall=0.
- lw $3 → addu $4,$3,$0 next → stall=1 one cycle; after bubble, ForwardA_E=11 (from W).
- jal (writes $31) → jr $31 one instruction later → ForwardA_D=10, no stall.
- addu $5 in M and $5 in W, E reads $5 → ForwardA_E=01 (M priority); writes to $0 → all selects 00, stall=0.
- reset asserted during lw-use stall → next cycle stall=0, all selects 00, shadow dst=0.
- MDU_STALL_EN: div, then mflo next → stall held 10 cycles (DIV_CYC); mult without HI/LO use → no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard/forwarding controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

  // Where an instruction's result comes from
  typedef enum logic [1:0] {
    RT_NONE = 2'b00,
    RT_ALU  = 2'b01,
    RT_MEM  = 2'b10,
    RT_PC8  = 2'b11
  } rtype_t;

  // Operand mux select encodings (D-stage muxes only use the first three)
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_ALU_M = 2'b01,
    FWD_PC8_M = 2'b10,
    FWD_W     = 2'b11
  } fwd_t;

  // Cycles until the result exists, counted when the producer enters E
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_MEM  = 2'd2;
  localparam logic [1:0] TNEW_PC8  = 2'd0;

  // Multiply/divide start encodings
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  // Shadow state carried down the E/M/W stages
  typedef struct packed {
    logic [4:0] dst;
    rtype_t     rtype;
    logic [1:0] tnew;
  } stage_t;

  function automatic logic [1:0] tnew_entry(input rtype_t rt);
    case (rt)
      RT_ALU:  return TNEW_ALU;
      RT_MEM:  return TNEW_MEM;
      RT_PC8:  return TNEW_PC8;
      default: return TNEW_NONE;
    endcase
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority comparator choosing an operand mux select from the producing stages.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: src = consumer register; dst_y = younger stage that masks M without
//   forwarding (tie to 0 when absent); dst_m/rtype_m and dst_w/rtype_w = older
//   producers; w_en enables W forwarding; sel = resulting mux select.
import hazard_pkg::*;

module fwd_sel (
  input  logic [4:0] src,
  input  logic [4:0] dst_y,
  input  logic [4:0] dst_m,
  input  rtype_t     rtype_m,
  input  logic [4:0] dst_w,
  input  rtype_t     rtype_w,
  input  logic       w_en,
  output fwd_t       sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (dst_y == src) begin
        // Youngest producer is still in E: it will stall or forward later
        sel = FWD_RF;
      end else if (dst_m == src) begin
        // An M match masks W even when M cannot supply the value yet
        if (rtype_m == RT_ALU)      sel = FWD_ALU_M;
        else if (rtype_m == RT_PC8) sel = FWD_PC8_M;
      end else if (w_en && (dst_w == src) && (rtype_w != RT_NONE)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline with E/M/W shadow state.
// Latency: selects and stall are combinational; shadow state advances each clk.
// Backpressure: stall freezes PC and F/D and forces a bubble into E (flush_E).
// Ports: rs_D/rt_D/tuse_*_D/dst_D/rtype_D describe the decode instruction;
//   md_start_D/md_use_D describe HI/LO activity; ForwardA/B_D drive the branch
//   compare muxes, ForwardA/B_E the ALU operand muxes; stall/flush_E control flow.
// Optional MDU_STALL_EN: adds a mult/div busy counter that stalls HI/LO users.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] dst_D,
  input  logic [1:0] rtype_D,
  input  logic [1:0] md_start_D,
  input  logic       md_use_D,
  output logic [1:0] ForwardA_D,
  output logic [1:0] ForwardB_D,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       stall,
  output logic       flush_E
);

  stage_t     st_e, st_m, st_w;
  logic [4:0] rs_e, rt_e;
  logic       data_stall, md_stall;
  fwd_t       fa_d, fb_d, fa_e, fb_e;

  // The youngest matching producer decides; an E match hides any M match.
  function automatic logic op_hazard(input logic [4:0] x, input logic [1:0] tuse,
                                     input stage_t e, input stage_t m);
    if (x == 5'd0)  return 1'b0;
    if (e.dst == x) return e.tnew > tuse;
    if (m.dst == x) return m.tnew > tuse;
    return 1'b0;
  endfunction

  assign data_stall = op_hazard(rs_D, tuse_rs_D, st_e, st_m) |
                      op_hazard(rt_D, tuse_rt_D, st_e, st_m);
  assign stall   = data_stall | md_stall;
  assign flush_E = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_e <= '0;
      st_m <= '0;
      st_w <= '0;
      rs_e <= 5'd0;
      rt_e <= 5'd0;
    end else begin
      if (stall) begin
        st_e <= '0;
        rs_e <= 5'd0;
        rt_e <= 5'd0;
      end else begin
        st_e <= '{dst: dst_D, rtype: rtype_t'(rtype_D), tnew: tnew_entry(rtype_t'(rtype_D))};
        rs_e <= rs_D;
        rt_e <= rt_D;
      end
      st_m <= '{dst: st_e.dst, rtype: st_e.rtype, tnew: tnew_dec(st_e.tnew)};
      st_w <= '{dst: st_m.dst, rtype: st_m.rtype, tnew: tnew_dec(st_m.tnew)};
    end
  end

`ifdef MDU_STALL_EN
  localparam int MD_W = $clog2(((MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC) + 1);

  logic [MD_W-1:0] md_busy;
  logic [1:0]      md_start_e;

  assign md_stall = md_use_D && ((md_busy != '0) || (md_start_e != MD_NONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      md_busy    <= '0;
      md_start_e <= MD_NONE;
    end else begin
      md_start_e <= stall ? MD_NONE : md_start_D;
      if (!stall && (md_start_D == MD_MULT))     md_busy <= MD_W'(MULT_CYC);
      else if (!stall && (md_start_D == MD_DIV)) md_busy <= MD_W'(DIV_CYC);
      else if (md_busy != '0)                    md_busy <= md_busy - MD_W'(1);
    end
  end

  logic unused_ok;
  assign unused_ok = ^st_w.tnew;
`else
  assign md_stall = 1'b0;

  logic unused_ok;
  assign unused_ok = (^{md_start_D, md_use_D, st_w.tnew}) ^ (MULT_CYC != DIV_CYC);
`endif

  // Decode compare operands: W reaches D through the register file bypass
  fwd_sel u_fwd_a_d (
    .src(rs_D), .dst_y(st_e.dst), .dst_m(st_m.dst), .rtype_m(st_m.rtype),
    .dst_w(st_w.dst), .rtype_w(st_w.rtype), .w_en(1'b0), .sel(fa_d)
  );
  fwd_sel u_fwd_b_d (
    .src(rt_D), .dst_y(st_e.dst), .dst_m(st_m.dst), .rtype_m(st_m.rtype),
    .dst_w(st_w.dst), .rtype_w(st_w.rtype), .w_en(1'b0), .sel(fb_d)
  );

  // Execute ALU operands: nothing younger than M can produce for E
  fwd_sel u_fwd_a_e (
    .src(rs_e), .dst_y(5'd0), .dst_m(st_m.dst), .rtype_m(st_m.rtype),
    .dst_w(st_w.dst), .rtype_w(st_w.rtype), .w_en(1'b1), .sel(fa_e)
  );
  fwd_sel u_fwd_b_e (
    .src(rt_e), .dst_y(5'd0), .dst_m(st_m.dst), .rtype_m(st_m.rtype),
    .dst_w(st_w.dst), .rtype_w(st_w.rtype), .w_en(1'b1), .sel(fb_e)
  );

  assign ForwardA_D = fa_d;
  assign ForwardB_D = fb_d;
  assign ForwardA_E = fa_e;
  assign ForwardB_E = fb_e;

endmodule
